sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares one SRAM macro (1 read port, 1 write port, per-word write enables, 1-cycle registered read) between NUM_REQ requesters.
- Sequences the macro's bulk initialisation after reset.
- Runs independent round-robin arbitration for the read and write ports, so one read and one write can issue per cycle.
- Returns read data tagged with requester id and forwards same-cycle write data, so reads never observe stale lanes.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 512, row width in bits.
- LOG_NUM_ROWS, 9, address width.
- WORD_SIZE, 64, write-enable granularity. NUM_WORDS = WIDTH/WORD_SIZE (derived).
- ID_W, $clog2(NUM_REQ), response id width (derived).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*LOG_NUM_ROWS  packed per-requester row address.
- req_wdata  in  NUM_REQ*WIDTH  packed write data.
- req_wmask  in  NUM_REQ*NUM_WORDS  packed per-word write mask.
- resp_valid  out  1  read data valid.
- resp_id  out  ID_W  requester index of the returned read.
- resp_data  out  WIDTH  read data.
- sram_reset  out  1  active-high synchronous init strobe to macro.
- sram_readAddr  out  LOG_NUM_ROWS  macro read address.
- sram_readData  in  WIDTH  macro read data.
- sram_writeAddr  out  LOG_NUM_ROWS  macro write address.
- sram_writeData  out  WIDTH  macro write data.
- sram_writeEnable  out  NUM_WORDS  macro per-word write enable.

Behaviour:
- Reset is asynchronous and active-low on reset_n; everything is clocked on clk.
- FSM states: S_INIT, S_RUN. Async reset forces S_INIT, rd_ptr=0, wr_ptr=0, resp_valid=0, fwd_valid=0.
- S_INIT:
  - sram_reset=1, req_ready=0, sram_writeEnable=0.
  - Transition to S_RUN on the first clk edge with reset_n high. The macro fills every row with all-ones on that edge.
- S_RUN: sram_reset=0.
  - Read candidates: req_valid & ~req_write. Write candidates: req_valid & req_write.
  - Each class grants at most one requester per cycle, round-robin. The search starts at its pointer.
  - On a grant, that pointer moves to (granted index + 1) mod NUM_REQ; otherwise it holds.
  - req_ready[i]=1 only for the granted read or write index in S_RUN. This is combinational and may depend on req_valid.
  - A transfer occurs when req_valid[i] & req_ready[i].
- Write grant, combinational same cycle:
  - sram_writeAddr, sram_writeData and sram_writeEnable are driven from the winner's addr, wdata and wmask.
  - With no write grant, sram_writeEnable=0.
  - An all-zero mask is still granted and consumes the slot.
- Read grant:
  - sram_readAddr is driven from the winner's address; with no read grant it holds its last value.
  - resp_valid=1 and resp_id=winner appear exactly one cycle later.
  - Back-to-back reads give one response per cycle. resp has no backpressure.
- Lane mapping (fixed by the macro): write lane i (wdata bits [i*WORD_SIZE +: WORD_SIZE]) returns on read lane NUM_WORDS-1-i, bit order within the lane preserved.
- Forwarding:
  - The macro returns old data when a read and a write to the same row are granted in the same cycle.
  - In that case the block registers wdata, wmask and fwd_valid.
  - The next cycle, resp_data replaces each lane with mask bit i set, using the mapping above. All other lanes come from sram_readData.
  - A write granted one or more cycles before the read needs no forwarding.
- Reset mid-operation: async assertion immediately drops resp_valid and sram_writeEnable and raises sram_reset. The in-flight response is discarded.

Decomposition:
- sram_arb_pkg holds:
  - state_t enum {S_INIT, S_RUN};
  - the lane_map function (lane i -> NUM_WORDS-1-i);
  - a merge-with-mask function.
- One sub-module, rr_arbiter (parameter N): inputs req[N] and advance; outputs a one-hot grant and an encoded index; holds its pointer internally.
- rr_arbiter is instantiated twice, once for reads and once for writes.

Test Plan:
- Init: release reset_n, then read row 5 -> exactly one cycle of sram_reset=1 with req_ready=0, then resp_data all-ones with resp_id correct 1 cycle after grant.
- Fairness: all 4 requesters hold read valid for 8 cycles -> grants 0,1,2,3,0,1,2,3, one resp per cycle, ids in matching order.
- Dual issue: req0 writes row 7, mask 0x01, data lane0=0xA5A5..; req1 reads row 9 same cycle -> both ready=1; row 7 lane 7 later reads 0xA5A5..
- Forwarding: write row 3, mask 0x81, plus read row 3 in the same cycle -> next-cycle resp lanes 7 and 0 hold the new data, other lanes all-ones.
- Reset mid-read: assert reset_n low the cycle after a read grant -> resp_valid 0 immediately, no response after release, init repeats.
- Mask 0: write granted with wmask=0 -> sram_writeEnable=0, wr_ptr advances, row content unchanged.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// sram_arb_pkg: shared types and helpers for the SRAM port arbiter.
//   state_t    - controller state (macro init vs. normal service)
//   lane_map   - write lane -> read lane mapping fixed by the macro wiring
//   merge_mask - bitwise select between old and new data under a bit mask
package sram_arb_pkg;

    typedef enum logic {S_INIT, S_RUN} state_t;

    // Upper bound on row width handled by merge_mask; callers zero-extend
    // their operands and truncate the result back to their own width.
    localparam int MERGE_MAX_W = 4096;

    // The macro swaps word order between its write and read ports.
    function automatic int lane_map(input int lane, input int num_words);
        return num_words - 1 - lane;
    endfunction

    function automatic logic [MERGE_MAX_W-1:0] merge_mask(
        input logic [MERGE_MAX_W-1:0] old_data,
        input logic [MERGE_MAX_W-1:0] new_data,
        input logic [MERGE_MAX_W-1:0] bit_mask
    );
        return (old_data & ~bit_mask) | (new_data & bit_mask);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester-side bus of the SRAM port arbiter.
//   req_valid/req_ready/req_write  per-requester handshake and direction
//   req_addr/req_wdata/req_wmask   per-requester row address, data, word mask
//   resp_valid/resp_id/resp_data   tagged read return (no backpressure)
// slave modport is the arbiter, master modport is the requester side.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 512,
    parameter int LOG_NUM_ROWS = 9,
    parameter int WORD_SIZE    = 64
);
    localparam int NUM_WORDS = WIDTH / WORD_SIZE;
    localparam int ID_W      = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ-1:0]                   req_ready;
    logic [NUM_REQ-1:0]                   req_write;
    logic [NUM_REQ-1:0][LOG_NUM_ROWS-1:0] req_addr;
    logic [NUM_REQ-1:0][WIDTH-1:0]        req_wdata;
    logic [NUM_REQ-1:0][NUM_WORDS-1:0]    req_wmask;
    logic                                 resp_valid;
    logic [ID_W-1:0]                      resp_id;
    logic [WIDTH-1:0]                     resp_data;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_id, resp_data
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_id, resp_data
    );

endinterface

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// rr_arbiter: single-grant round-robin arbiter.
//   clk, reset_n  clock, async active-low reset (pointer -> 0)
//   i_req         request vector
//   i_advance     allow the pointer to move on a grant
//   o_grant       one-hot grant, o_idx its encoded index, o_valid any grant
// Search begins at the pointer; after a grant the pointer moves to winner+1.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);
    logic [IDX_W-1:0] r_ptr;

    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(r_ptr) + k;
            if (j >= N) j = j - N;
            if (!o_valid && i_req[j]) begin
                o_valid    = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ptr <= '0;
        else if (i_advance && o_valid)
            r_ptr <= IDX_W'((int'(o_idx) + 1) % N);
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 1R1W SRAM macro between NUM_REQ requesters.
//   clk, reset_n        clock, async active-low reset
//   bus (slave)         requester handshake, write payload, tagged read return
//   sram_reset          init strobe; macro fills every row with ones
//   sram_readAddr/Data  macro read port (data registered one cycle)
//   sram_write*         macro write port with per-word enables
// One read and one write may issue per cycle, each with its own round-robin
// arbiter. A read that hits the row being written in the same cycle would
// see old data from the macro, so the write is captured and merged into
// the response on the following cycle.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 512,
    parameter int LOG_NUM_ROWS = 9,
    parameter int WORD_SIZE    = 64,
    localparam int NUM_WORDS   = WIDTH / WORD_SIZE,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sram_port_arbiter_if.slave      bus,
    output logic                    sram_reset,
    output logic [LOG_NUM_ROWS-1:0] sram_readAddr,
    input  logic [WIDTH-1:0]        sram_readData,
    output logic [LOG_NUM_ROWS-1:0] sram_writeAddr,
    output logic [WIDTH-1:0]        sram_writeData,
    output logic [NUM_WORDS-1:0]    sram_writeEnable
);
    state_t                  r_state;
    logic                    r_resp_valid;
    logic [ID_W-1:0]         r_resp_id;
    logic [LOG_NUM_ROWS-1:0] r_rd_addr;
    logic                    r_fwd_valid;
    logic [WIDTH-1:0]        r_fwd_data;
    logic [NUM_WORDS-1:0]    r_fwd_mask;

    logic                    w_run;
    logic [NUM_REQ-1:0]      w_rd_req, w_wr_req, w_rd_gnt, w_wr_gnt;
    logic [ID_W-1:0]         w_rd_idx, w_wr_idx;
    logic                    w_rd_vld, w_wr_vld, w_fwd_hit;
    logic [WIDTH-1:0]        w_fwd_row, w_fwd_bits;

    assign w_run    = (r_state == S_RUN);
    // Gating candidates keeps both arbiters and req_ready idle during init.
    assign w_rd_req = bus.req_valid & ~bus.req_write & {NUM_REQ{w_run}};
    assign w_wr_req = bus.req_valid &  bus.req_write & {NUM_REQ{w_run}};

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk(clk), .reset_n(reset_n), .i_req(w_rd_req), .i_advance(w_run),
        .o_grant(w_rd_gnt), .o_idx(w_rd_idx), .o_valid(w_rd_vld)
    );

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk(clk), .reset_n(reset_n), .i_req(w_wr_req), .i_advance(w_run),
        .o_grant(w_wr_gnt), .o_idx(w_wr_idx), .o_valid(w_wr_vld)
    );

    assign bus.req_ready    = w_rd_gnt | w_wr_gnt;
    assign sram_reset       = ~w_run;
    assign sram_readAddr    = w_rd_vld ? bus.req_addr[w_rd_idx] : r_rd_addr;
    assign sram_writeAddr   = bus.req_addr[w_wr_idx];
    assign sram_writeData   = bus.req_wdata[w_wr_idx];
    assign sram_writeEnable = w_wr_vld ? bus.req_wmask[w_wr_idx] : '0;
    assign w_fwd_hit        = w_rd_vld & w_wr_vld &
                              (bus.req_addr[w_rd_idx] == bus.req_addr[w_wr_idx]);

    // Place captured write lanes where the macro would have returned them.
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_lane
        localparam int L = lane_map(g, NUM_WORDS);
        assign w_fwd_row[L*WORD_SIZE +: WORD_SIZE]  = r_fwd_data[g*WORD_SIZE +: WORD_SIZE];
        assign w_fwd_bits[L*WORD_SIZE +: WORD_SIZE] = {WORD_SIZE{r_fwd_valid & r_fwd_mask[g]}};
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_data  = WIDTH'(merge_mask(MERGE_MAX_W'(sram_readData),
                                              MERGE_MAX_W'(w_fwd_row),
                                              MERGE_MAX_W'(w_fwd_bits)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_INIT;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_rd_addr    <= '0;
            r_fwd_valid  <= 1'b0;
            r_fwd_data   <= '0;
            r_fwd_mask   <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    // Macro fills all rows on this edge; service starts next cycle.
                    r_state      <= S_RUN;
                    r_resp_valid <= 1'b0;
                    r_fwd_valid  <= 1'b0;
                end
                default: begin
                    r_resp_valid <= w_rd_vld;
                    r_resp_id    <= w_rd_idx;
                    r_fwd_valid  <= w_fwd_hit;
                    if (w_rd_vld) r_rd_addr <= bus.req_addr[w_rd_idx];
                    if (w_fwd_hit) begin
                        r_fwd_data <= bus.req_wdata[w_wr_idx];
                        r_fwd_mask <= bus.req_wmask[w_wr_idx];
                    end
                end
            endcase
        end
    end

endmodule
